// File: rtl/fir_pkg.sv
// Shared definitions for the streaming N-tap FIR: result-width rule,
// coefficient reset value and the default coefficient type.
package fir_pkg;

  localparam int FIR_COEF_W   = 8;
  localparam int COEF_DEFAULT = 1;

  typedef logic [FIR_COEF_W-1:0] coef_t;

  // Full-precision width of an unsigned TAPS-term sum of products.
  function automatic int calc_out_w(input int taps, input int data_w, input int coef_w);
    return data_w + coef_w + $clog2(taps);
  endfunction

endpackage

// File: rtl/fir_delay_line.sv
// TAPS x DATA_W sample shift register; tap 0 is the newest sample.
// Clear wins over shift enable.
module fir_delay_line
  import fir_pkg::*;
#(
  parameter int TAPS   = 4,
  parameter int DATA_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clear,
  input  logic [DATA_W-1:0]        din,
  output logic [TAPS*DATA_W-1:0]   taps
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taps <= '0;
    end else if (clear) begin
      taps <= '0;
    end else if (en) begin
      taps <= {taps[(TAPS-1)*DATA_W-1:0], din};
    end
  end

endmodule

// File: rtl/fir_stream_ntap.sv
// Unsigned N-tap FIR with valid/ready streaming, run-time coefficients,
// synchronous clear, registered output and a primed flag.
module fir_stream_ntap
  import fir_pkg::*;
#(
  parameter int TAPS   = 4,
  parameter int DATA_W = 4,
  parameter int COEF_W = FIR_COEF_W,
  parameter int OUT_W  = calc_out_w(TAPS, DATA_W, COEF_W)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    coef_we,
  input  logic [$clog2(TAPS)-1:0] coef_addr,
  input  logic [COEF_W-1:0]       coef_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        out_data,
  output logic                    primed
);

  localparam int CW = $clog2(TAPS + 1);
  localparam int PW = DATA_W + COEF_W;

  logic                   accept;
  logic                   coef_hit;
  logic [TAPS*DATA_W-1:0] taps;
  logic [TAPS*DATA_W-1:0] shifted;
  logic [COEF_W-1:0]      h [TAPS];
  logic [CW-1:0]          fill;
  logic [OUT_W-1:0]       y;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign coef_hit = coef_we && (int'(coef_addr) < TAPS);
  assign primed   = (fill == CW'(TAPS));

  fir_delay_line #(
    .TAPS   (TAPS),
    .DATA_W (DATA_W)
  ) u_delay (
    .clk   (clk),
    .rst   (rst),
    .en    (accept),
    .clear (clear),
    .din   (in_data),
    .taps  (taps)
  );

  // The result uses the post-shift window, so the new sample sits at tap 0.
  assign shifted = {taps[(TAPS-1)*DATA_W-1:0], in_data};

  always_comb begin
    y = '0;
    for (int k = 0; k < TAPS; k++) begin
      y = y + OUT_W'(PW'(h[k]) * PW'(shifted[k*DATA_W +: DATA_W]));
    end
  end

  // A write lands at the edge, so an accept in the same cycle still sees old h.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) h[k] <= COEF_W'(COEF_DEFAULT);
    end else if (coef_hit) begin
      h[coef_addr] <= coef_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill <= '0;
    end else if (clear) begin
      fill <= '0;
    end else if (accept && !primed) begin
      fill <= fill + 1'b1;
    end
  end

  // Output stage: load on accept, drain on a take with no new result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (clear) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= y;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_stream_ntap.sv
// Directed bench for fir_stream_ntap at TAPS=4, DATA_W=4, COEF_W=8.
module tb_fir_stream_ntap;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_data = '0;
  logic        coef_we = 1'b0;
  logic [1:0]  coef_addr = '0;
  logic [7:0]  coef_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [13:0] out_data;
  logic        primed;

  int n_checks = 0;
  int n_fail   = 0;

  fir_stream_ntap #(.TAPS(4), .DATA_W(4), .COEF_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .primed    (primed)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    tick; tick;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %0b want 0", out_valid); end
    n_checks++; if (out_data !== 14'd0) begin n_fail++; $display("FAIL rst_out_data got %0d want 0", out_data); end
    n_checks++; if (primed !== 1'b0) begin n_fail++; $display("FAIL rst_primed got %0b want 0", primed); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %0b want 1", in_ready); end
    rst = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 4'd3;
    for (int i = 1; i <= 4; i++) begin
      tick;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL movsum_valid[%0d] got %0b want 1", i, out_valid); end
      n_checks++; if (out_data !== 14'(3 * i)) begin n_fail++; $display("FAIL movsum_data[%0d] got %0d want %0d", i, out_data, 3 * i); end
      n_checks++; if (primed !== (i == 4)) begin n_fail++; $display("FAIL movsum_primed[%0d] got %0b want %0b", i, primed, i == 4); end
    end
    in_valid = 1'b0;
    tick;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid got %0b want 0", out_valid); end
  endtask

  task automatic test_collision;
    clear = 1'b1;
    tick;
    clear = 1'b0;
    coef_we = 1'b1; coef_addr = 2'd0; coef_data = 8'd7;
    in_valid = 1'b1; in_data = 4'd2;
    tick;
    coef_we = 1'b0;
    n_checks++; if (out_data !== 14'd2) begin n_fail++; $display("FAIL collide_old_h got %0d want 2", out_data); end
    in_data = 4'd0;
    tick;
    n_checks++; if (out_data !== 14'd2) begin n_fail++; $display("FAIL collide_h1 got %0d want 2", out_data); end
    tick;
    n_checks++; if (out_data !== 14'd2) begin n_fail++; $display("FAIL collide_h2 got %0d want 2", out_data); end
    in_data = 4'd1;
    tick;
    n_checks++; if (out_data !== 14'd9) begin n_fail++; $display("FAIL collide_new_h0 got %0d want 9", out_data); end
    in_valid = 1'b0;
    tick;
  endtask

  task automatic test_coef;
    logic [7:0] hv [4] = '{8'd1, 8'd2, 8'd2, 8'd1};
    int exp_y [4] = '{7, 17, 26, 30};
    for (int k = 0; k < 4; k++) begin
      coef_we = 1'b1; coef_addr = 2'(k); coef_data = hv[k];
      tick;
    end
    coef_we = 1'b0;
    in_valid = 1'b1; in_data = 4'd5;
    for (int i = 0; i < 4; i++) begin
      tick;
      n_checks++; if (out_data !== 14'(exp_y[i])) begin n_fail++; $display("FAIL coef_y[%0d] got %0d want %0d", i, out_data, exp_y[i]); end
    end
    in_valid = 1'b0;
    tick;
  endtask

  task automatic test_backpressure;
    clear = 1'b1;
    tick;
    clear = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 4'd1;
    tick;
    n_checks++; if (out_data !== 14'd1) begin n_fail++; $display("FAIL bp_first got %0d want 1", out_data); end
    in_data = 4'd2;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d] got %0b want 0", i, in_ready); end
      tick;
      n_checks++; if (out_valid !== 1'b1 || out_data !== 14'd1) begin n_fail++; $display("FAIL bp_hold[%0d] got v=%0b d=%0d want v=1 d=1", i, out_valid, out_data); end
    end
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %0b want 1", in_ready); end
    tick;
    n_checks++; if (out_data !== 14'd4) begin n_fail++; $display("FAIL bp_resume1 got %0d want 4", out_data); end
    in_data = 4'd3;
    tick;
    n_checks++; if (out_data !== 14'd9) begin n_fail++; $display("FAIL bp_resume2 got %0d want 9", out_data); end
    in_valid = 1'b0;
    tick;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got %0b want 0", out_valid); end
  endtask

  task automatic test_clear;
    int exp_y [3] = '{20, 35, 48};
    in_valid = 1'b1; in_data = 4'd9;
    for (int i = 0; i < 3; i++) begin
      tick;
      n_checks++; if (out_data !== 14'(exp_y[i])) begin n_fail++; $display("FAIL pre_clear_y[%0d] got %0d want %0d", i, out_data, exp_y[i]); end
    end
    clear = 1'b1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL clear_in_ready got %0b want 1", in_ready); end
    tick;
    clear = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clear_valid got %0b want 0", out_valid); end
    n_checks++; if (primed !== 1'b0) begin n_fail++; $display("FAIL clear_primed got %0b want 0", primed); end
    tick;
    n_checks++; if (out_valid !== 1'b1 || out_data !== 14'd9) begin n_fail++; $display("FAIL post_clear_y got v=%0b d=%0d want v=1 d=9", out_valid, out_data); end
    tick;
    n_checks++; if (out_data !== 14'd27) begin n_fail++; $display("FAIL post_clear_y2 got %0d want 27", out_data); end
    n_checks++; if (primed !== 1'b0) begin n_fail++; $display("FAIL post_clear_primed got %0b want 0", primed); end
  endtask

  task automatic test_async_reset;
    int exp_max [4] = '{5355, 8670, 11985, 15300};
    tick;
    n_checks++; if (out_data !== 14'd45) begin n_fail++; $display("FAIL ar_pre3 got %0d want 45", out_data); end
    tick;
    n_checks++; if (out_data !== 14'd54 || primed !== 1'b1) begin n_fail++; $display("FAIL ar_pre4 got d=%0d p=%0b want d=54 p=1", out_data, primed); end
    in_valid = 1'b0; out_ready = 1'b0;
    tick;
    #3;
    rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid got %0b want 0", out_valid); end
    n_checks++; if (out_data !== 14'd0) begin n_fail++; $display("FAIL ar_data got %0d want 0", out_data); end
    n_checks++; if (primed !== 1'b0) begin n_fail++; $display("FAIL ar_primed got %0b want 0", primed); end
    tick;
    rst = 1'b0;
    out_ready = 1'b1; in_valid = 1'b1; in_data = 4'd2;
    for (int i = 1; i <= 4; i++) begin
      tick;
      n_checks++; if (out_data !== 14'(2 * i)) begin n_fail++; $display("FAIL ar_h1[%0d] got %0d want %0d", i, out_data, 2 * i); end
    end
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      coef_we = 1'b1; coef_addr = 2'(k); coef_data = 8'd255;
      tick;
    end
    coef_we = 1'b0;
    in_valid = 1'b1; in_data = 4'd15;
    for (int i = 0; i < 4; i++) begin
      tick;
      n_checks++; if (out_data !== 14'(exp_max[i])) begin n_fail++; $display("FAIL max_y[%0d] got %0d want %0d", i, out_data, exp_max[i]); end
    end
    in_valid = 1'b0;
    tick;
  endtask

  initial begin
    test_reset;
    test_collision;
    test_coef;
    test_backpressure;
    test_clear;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_stream_ntap.md
# fir_stream_ntap

Parametrised N-tap unsigned FIR filter with a valid/ready streaming interface, run-time loadable coefficients, a synchronous clear and a primed flag. It replaces the fixed 3-tap, unregistered filter in the datapath. Sample and result streams are backpressure-aware, and the output is registered.

## Interface
- `TAPS`, 4: number of taps, at least 2.
- `DATA_W`, 4: input sample width, unsigned.
- `COEF_W`, 8: coefficient width, unsigned.
- `OUT_W`, DATA_W+COEF_W+$clog2(TAPS): result width. Overflow is impossible by construction.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `clear`  in  1  synchronous flush of the delay line and the output stage.
- `in_valid`  in  1  sample offered.
- `in_ready`  out  1  sample can be accepted.
- `in_data`  in  DATA_W  sample x.
- `coef_we`  in  1  coefficient write strobe.
- `coef_addr`  in  $clog2(TAPS)  tap index k.
- `coef_data`  in  COEF_W  new h[k].
- `out_valid`  out  1  result held.
- `out_ready`  in  1  consumer takes the result.
- `out_data`  out  OUT_W  y.
- `primed`  out  1  TAPS samples accepted since the last reset or clear.

## Operation
- Accept occurs when `in_valid && in_ready`.
- `in_ready = !out_valid || out_ready`. This is combinational, with no dependency on `in_valid`.
- On accept:
  - the delay line shifts: d[0] takes `in_data`, and d[k] takes the old d[k-1];
  - the output register loads y = Σ h[k]·d'[k], where d' is the post-shift contents (d'[0] = the new sample);
  - `out_valid` is set.
- When `out_valid && out_ready` with no accept, `out_valid` clears. When both happen in the same cycle, `out_valid` stays 1 and the new result replaces the old one.
- `out_data` is held stable while `out_valid && !out_ready`.
- Coefficient write: when `coef_we` is high, h[coef_addr] is updated at the edge.
  - A write in the same cycle as an accept does not affect that accept's result; it uses the old h.
  - `coef_addr` ≥ TAPS is ignored.
  - Writes are permitted at any time, including while stalled.
- `clear` has priority over accept. It zeroes d[*], clears `out_valid` and `primed`, and resets the fill counter. Coefficients are kept. `in_ready` is unaffected; any sample offered in the clear cycle is dropped.
- `primed`: a fill counter saturates at TAPS and increments on accept. `primed` is 1 when the counter equals TAPS.
- Arithmetic is all unsigned. Products are DATA_W+COEF_W bits, and the adder tree is sized to OUT_W. There is no truncation or rounding.

## Timing
- Reset values:
  - `out_valid` 0, `out_data` 0, `primed` 0;
  - d[*] 0, fill counter 0;
  - h[k] = 1 for all k, so the filter is a moving sum after reset.
- Latency: the result for an accepted sample is visible on `out_data` with `out_valid` = 1 the next cycle.
- Throughput: one sample per cycle while `out_ready` is held high.
- Reset asserted mid-stream immediately returns all state to the reset values above. The first edge after deassertion behaves as a normal cycle.
- When constant x has been accepted for TAPS consecutive samples and h[*] = 1, the next `out_data` equals TAPS·x.

## Structure
- `fir_pkg` holds:
  - the function computing `OUT_W` from TAPS/DATA_W/COEF_W;
  - the default coefficient constant (1);
  - a `coef_t` typedef parametrised by COEF_W, supplied via a package-level localparam default.
- One sub-module, `fir_delay_line` (TAPS × DATA_W shift register with enable and clear, exposing all taps), is natural.
- The coefficient file, MAC tree, handshake and fill counter live in the top.

## Test plan
All scenarios use TAPS=4, DATA_W=4, COEF_W=8 (OUT_W=14).
- Reset defaults: hold `rst`, then release and stream x=3 ×4 with `out_ready`=1. Required outputs are 3, 6, 9, 12; `primed` rises on the cycle after the 4th accept.
- Coefficients 1,2,2,1: write via `coef_we`, then stream 5,5,5,5. Final y = 30.
- Write/accept collision: h[0] 1→7 in the same cycle as an accept, with x=2 and d=0. That result is 2; the next accept of 0 gives 2·h[1] = 2.
- Backpressure: hold `out_ready`=0 after one result. `in_ready`=0, `out_data` is held, and `in_valid` samples are not consumed. Release, and the stream continues with no loss or duplication.
- Clear mid-stream: after 3 accepts of x=9, pulse `clear` while `in_valid`=1. Then `out_valid`=0, `primed`=0, and the next accept of 9 yields 9.
- Async reset mid-stream: assert `rst` between edges with `out_valid`=1. `out_valid`, `out_data` and `primed` go to 0 immediately, and h[*] returns to 1. Max-value check: x=15 ×4 with h=255 gives 15300, no wrap.
